// File: rtl/pipelined_adder_acc_pkg.sv
// Shared definitions for the pipelined adder/accumulator: mode encodings,
// output-register states and the flag record carried with each result.
package pipelined_adder_acc_pkg;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_ACC = 2'b10;
   localparam logic [1:0] MODE_CLR = 2'b11;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   typedef struct packed {
      logic carry;
      logic ovf;
   } flag_t;

   function automatic logic mode_is_sub(input logic [1:0] mode);
      return mode == MODE_SUB;
   endfunction

   function automatic logic mode_uses_acc(input logic [1:0] mode);
      return mode == MODE_ACC;
   endfunction

endpackage

// File: rtl/pipelined_adder_acc_core.sv
// Combinational add/subtract core with carry and signed-overflow flags.
// Clamps on signed overflow when ADDER_SATURATE_EN is defined.
module add_sub_core
   import pipelined_adder_acc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   output logic [WIDTH-1:0] Sum,
   output logic             CarryOut,
   output logic             Overflow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   raw;
   logic [WIDTH-1:0] wrap;
   logic             ovf;

   always_comb begin
      b_eff = Sub ? ~B : B;
      raw   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Sub};
      wrap  = raw[WIDTH-1:0];
      // with B already inverted for subtract, one rule covers both modes
      ovf   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (wrap[WIDTH-1] != A[WIDTH-1]);
   end

`ifdef ADDER_SATURATE_EN
   logic [WIDTH-1:0] sat_pos;
   logic [WIDTH-1:0] sat_neg;

   always_comb begin
      sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
      sat_neg = {1'b1, {(WIDTH-1){1'b0}}};
      // on overflow the true result keeps the sign of A
      if (ovf) begin
         Sum = A[WIDTH-1] ? sat_neg : sat_pos;
      end else begin
         Sum = wrap;
      end
   end
`else
   assign Sum = wrap;
`endif

   assign CarryOut = raw[WIDTH];
   assign Overflow = ovf;

endmodule

// File: rtl/pipelined_adder_acc.sv
// Registered adder/subtractor/accumulator with valid/ready on both sides.
// Optional clamping on signed overflow: define ADDER_SATURATE_EN.
//
// state    | meaning
// ST_EMPTY | no result held, OutValid=0
// ST_FULL  | result held in Sum/flags, OutValid=1
module pipelined_adder_acc
   import pipelined_adder_acc_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] Input1,
   input  logic [WIDTH-1:0] Input2,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Sum,
   output logic             CarryOut,
   output logic             Overflow,
   output logic [WIDTH-1:0] AccValue
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      flag_t            flags;
   } res_t;

   logic [0:0]       state_q, state_d;
   res_t             res_q, res_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             accept;
   logic             transfer;

   logic [WIDTH-1:0] core_a, core_b, core_sum;
   logic             core_sub, core_carry, core_ovf;
   res_t             new_res;

   assign InReady  = (state_q == ST_EMPTY) || OutReady;
   assign accept   = InValid && InReady;
   assign transfer = (state_q == ST_FULL) && OutReady;

   always_comb begin
      core_a   = mode_uses_acc(Mode) ? acc_q : Input1;
      core_b   = mode_uses_acc(Mode) ? Input1 : Input2;
      core_sub = mode_is_sub(Mode);
   end

   add_sub_core #(
      .WIDTH    (WIDTH)
   ) u_core (
      .A        (core_a),
      .B        (core_b),
      .Sub      (core_sub),
      .Sum      (core_sum),
      .CarryOut (core_carry),
      .Overflow (core_ovf)
   );

   always_comb begin
      new_res.sum         = core_sum;
      new_res.flags.carry = core_carry;
      new_res.flags.ovf   = core_ovf;
      if (Mode == MODE_CLR) begin
         new_res.sum   = ACC_INIT;
         new_res.flags = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      acc_d   = acc_q;
      if (accept) begin
         state_d = ST_FULL;
         res_d   = new_res;
         if (Mode == MODE_ACC) begin
            acc_d = core_sum;
         end else if (Mode == MODE_CLR) begin
            acc_d = ACC_INIT;
         end
      end else if (transfer) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_EMPTY;
         res_q   <= '0;
         acc_q   <= ACC_INIT;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         acc_q   <= acc_d;
      end
   end

   assign OutValid = (state_q == ST_FULL);
   assign Sum      = res_q.sum;
   assign CarryOut = res_q.flags.carry;
   assign Overflow = res_q.flags.ovf;
   assign AccValue = acc_q;

endmodule

// File: tb/tb_pipelined_adder_acc.sv
// Directed-vector and scoreboard bench for pipelined_adder_acc (WIDTH=8).
module tb_pipelined_adder_acc;

   localparam logic [1:0] M_ADD = 2'b00;
   localparam logic [1:0] M_SUB = 2'b01;
   localparam logic [1:0] M_ACC = 2'b10;
   localparam logic [1:0] M_CLR = 2'b11;

`ifdef ADDER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       InValid;
   logic [1:0] Mode;
   logic [7:0] Input1, Input2;
   logic       OutReady;

   logic       InReady, OutValid, CarryOut, Overflow;
   logic [7:0] Sum, AccValue;
   logic       InReady2, OutValid2, CarryOut2, Overflow2;
   logic [7:0] Sum2, AccValue2;

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   pipelined_adder_acc #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .Mode(Mode), .Input1(Input1), .Input2(Input2), .OutValid(OutValid),
      .OutReady(OutReady), .Sum(Sum), .CarryOut(CarryOut),
      .Overflow(Overflow), .AccValue(AccValue)
   );

   pipelined_adder_acc #(.WIDTH(8), .ACC_INIT(8'h5A)) dut2 (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady2),
      .Mode(Mode), .Input1(Input1), .Input2(Input2), .OutValid(OutValid2),
      .OutReady(OutReady), .Sum(Sum2), .CarryOut(CarryOut2),
      .Overflow(Overflow2), .AccValue(AccValue2)
   );

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum_w;
      logic [7:0] sum_s;
      logic       c;
      logic       v;
      logic [7:0] acc_w;
      logic [7:0] acc_s;
   } vec_t;

   vec_t vecs [15];

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference: {carry, ovf, sum} from arithmetic on integers
   function automatic logic [9:0] model(input logic [1:0] m, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] acc);
      logic [7:0] x, y, s;
      logic [8:0] r;
      logic       c, v;
      int         ts;
      if (m == M_CLR) return 10'd0;
      x = (m == M_ACC) ? acc : a;
      y = (m == M_ACC) ? a : b;
      if (m == M_SUB) begin
         r  = {1'b0, x} - {1'b0, y};
         c  = ~r[8];
         ts = int'($signed(x)) - int'($signed(y));
      end else begin
         r  = {1'b0, x} + {1'b0, y};
         c  = r[8];
         ts = int'($signed(x)) + int'($signed(y));
      end
      s = r[7:0];
      v = (ts > 127) || (ts < -128);
      if (SAT && ts > 127)  s = 8'h7F;
      if (SAT && ts < -128) s = 8'h80;
      return {c, v, s};
   endfunction

   initial begin
      logic [9:0] q[$];
      logic [9:0] front, r;
      logic [7:0] macc;
      logic       exp_valid;
      int         accepted, cyc;

      vecs[0]  = '{M_ADD, 8'd200, 8'd100, 8'd44,  8'd44,  1'b1, 1'b0, 8'd0,   8'd0};
      vecs[1]  = '{M_ADD, 8'd100, 8'd100, 8'd200, 8'd127, 1'b0, 1'b1, 8'd0,   8'd0};
      vecs[2]  = '{M_SUB, 8'd5,   8'd7,   8'd254, 8'd254, 1'b0, 1'b0, 8'd0,   8'd0};
      vecs[3]  = '{M_SUB, 8'd128, 8'd1,   8'd127, 8'd128, 1'b1, 1'b1, 8'd0,   8'd0};
      vecs[4]  = '{M_ADD, 8'd156, 8'd156, 8'd56,  8'd128, 1'b1, 1'b1, 8'd0,   8'd0};
      vecs[5]  = '{M_ACC, 8'd10,  8'd99,  8'd10,  8'd10,  1'b0, 1'b0, 8'd10,  8'd10};
      vecs[6]  = '{M_ACC, 8'd20,  8'd0,   8'd30,  8'd30,  1'b0, 1'b0, 8'd30,  8'd30};
      vecs[7]  = '{M_ACC, 8'd30,  8'd0,   8'd60,  8'd60,  1'b0, 1'b0, 8'd60,  8'd60};
      vecs[8]  = '{M_CLR, 8'd77,  8'd3,   8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   8'd0};
      vecs[9]  = '{M_ACC, 8'd100, 8'd0,   8'd100, 8'd100, 1'b0, 1'b0, 8'd100, 8'd100};
      vecs[10] = '{M_ACC, 8'd100, 8'd0,   8'd200, 8'd127, 1'b0, 1'b1, 8'd200, 8'd127};
      vecs[11] = '{M_ACC, 8'd200, 8'd0,   8'd144, 8'd71,  1'b1, 1'b0, 8'd144, 8'd71};
      vecs[12] = '{M_CLR, 8'd1,   8'd1,   8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   8'd0};
      vecs[13] = '{M_SUB, 8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 8'd0,   8'd0};
      vecs[14] = '{M_SUB, 8'd0,   8'd1,   8'd255, 8'd255, 1'b0, 1'b0, 8'd0,   8'd0};

      // reset held two cycles with a valid input present
      Reset = 1'b1; InValid = 1'b1; Mode = M_ADD; Input1 = 8'd200; Input2 = 8'd100;
      OutReady = 1'b1;
      tick(); tick();
      chk("rst_outvalid", OutValid, 0);
      chk("rst_sum", Sum, 0);
      chk("rst_flags", {CarryOut, Overflow}, 0);
      chk("rst_acc", AccValue, 0);
      chk("rst_acc_init", AccValue2, 8'h5A);
      Reset = 1'b0; InValid = 1'b0;
      tick();
      chk("post_rst_no_result", OutValid, 0);

      foreach (vecs[i]) begin
         Mode = vecs[i].mode; Input1 = vecs[i].a; Input2 = vecs[i].b; InValid = 1'b1;
         tick();
         chk($sformatf("vec%0d_valid", i), OutValid, 1);
         chk($sformatf("vec%0d_sum", i), Sum, SAT ? vecs[i].sum_s : vecs[i].sum_w);
         chk($sformatf("vec%0d_carry", i), CarryOut, vecs[i].c);
         chk($sformatf("vec%0d_ovf", i), Overflow, vecs[i].v);
         chk($sformatf("vec%0d_acc", i), AccValue, SAT ? vecs[i].acc_s : vecs[i].acc_w);
      end
      InValid = 1'b0;
      tick();
      chk("idle_drop_valid", OutValid, 0);

      // clear loads ACC_INIT, not zero
      Mode = M_CLR; InValid = 1'b1;
      tick();
      chk("clr_init_sum", Sum2, 8'h5A);
      chk("clr_init_flags", {OutValid2, CarryOut2, Overflow2}, 3'b100);
      Mode = M_ACC; Input1 = 8'd6;
      #1 chk("dut2_inready", InReady2, 1);
      tick();
      chk("acc_from_init", {Sum2, AccValue2}, {8'h60, 8'h60});
      chk("acc_from_zero", Sum, 6);
      InValid = 1'b0;
      tick();

      // backpressure: held result, input stalled, then same-cycle replace
      OutReady = 1'b0; Mode = M_ADD; Input1 = 8'd1; Input2 = 8'd2; InValid = 1'b1;
      tick();
      chk("bp_first", {OutValid, Sum}, {1'b1, 8'd3});
      Input1 = 8'd10; Input2 = 8'd20;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("bp_inready%0d", k), InReady, 0);
         tick();
         chk($sformatf("bp_hold%0d", k), {OutValid, Sum}, {1'b1, 8'd3});
      end
      OutReady = 1'b1;
      #1 chk("bp_release_ready", InReady, 1);
      tick();
      chk("bp_replace", {OutValid, Sum}, {1'b1, 8'd30});
      InValid = 1'b0;
      tick();
      chk("bp_drain", OutValid, 0);

      // reset while a result is pending
      OutReady = 1'b0; Mode = M_ACC; Input1 = 8'd5; InValid = 1'b1;
      tick();
      chk("pre_rst_acc", {OutValid, AccValue}, {1'b1, 8'd11});
      Reset = 1'b1;
      tick();
      chk("mid_rst", {OutValid, Sum, AccValue}, 17'd0);
      Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      tick();
      chk("mid_rst_after", OutValid, 0);

      // random stream against a queue scoreboard
      macc = 8'd0; accepted = 0; cyc = 0;
      while (accepted < 100 && cyc < 3000) begin
         InValid  = ($urandom_range(0, 3) != 0);
         OutReady = ($urandom_range(0, 2) != 0);
         Mode     = 2'($urandom_range(0, 3));
         Input1   = 8'($urandom);
         Input2   = 8'($urandom);
         #1;
         exp_valid = (q.size() != 0);
         chk("rnd_valid", OutValid, exp_valid);
         chk("rnd_inready", InReady, !exp_valid || OutReady);
         chk("rnd_acc", AccValue, macc);
         if (exp_valid && OutReady) begin
            front = q.pop_front();
            chk("rnd_result", {CarryOut, Overflow, Sum}, front);
         end
         if (InValid && (!exp_valid || OutReady)) begin
            r = model(Mode, Input1, Input2, macc);
            q.push_back(r);
            if (Mode == M_ACC) macc = r[7:0];
            if (Mode == M_CLR) macc = 8'd0;
            accepted++;
         end
         tick();
         cyc++;
      end
      checks++;
      if (accepted < 100) begin
         failures++;
         $display("FAIL rnd_timeout: accepted %0d of 100", accepted);
      end
      InValid = 1'b0; OutReady = 1'b1;
      #1;
      if (q.size() != 0) begin
         front = q.pop_front();
         chk("rnd_last", {OutValid, CarryOut, Overflow, Sum}, {1'b1, front});
      end
      tick();
      chk("rnd_empty", OutValid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_acc.md
Name: pipelined_adder_acc

Overview:
- Parametrised successor to the team's 8-bit combinational adder.
- Registered adder/subtractor with a running accumulator, carry and overflow flags, and valid/ready handshakes on input and output.
- Sits between the operand-select datapath and the result bus.
- One-cycle latency, full throughput; a stalled output holds its data.

Parameters:
- WIDTH, 8, operand, result and accumulator width in bits (min 2).
- ACC_INIT, 0, value loaded into the accumulator at reset and on a clear op (WIDTH bits).

Ports:
- Clk  input  1  rising-edge clock, the only clock.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operands and Mode are valid this cycle.
- InReady  output  1  block accepts the input this cycle.
- Mode  input  2  00 add, 01 subtract, 10 accumulate, 11 clear.
- Input1  input  WIDTH  operand A.
- Input2  input  WIDTH  operand B; ignored in modes 10 and 11.
- OutValid  output  1  Sum and the flags hold a valid result.
- OutReady  input  1  downstream accepts the result.
- Sum  output  WIDTH  registered result.
- CarryOut  output  1  unsigned carry out; borrow-not for subtract.
- Overflow  output  1  two's-complement signed overflow.
- AccValue  output  WIDTH  current accumulator contents.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: OutValid=0, Sum=0, CarryOut=0, Overflow=0, accumulator=ACC_INIT.
- Reset priority: Reset overrides all other activity, including mid-transfer. A result pending at reset is discarded.
- Handshake: InReady = !OutValid || OutReady (combinational, no dependency on InValid).
  - Accept = InValid && InReady.
  - Output transfer = OutValid && OutReady.
- Latency: result registered on the accept edge; OutValid=1 the next cycle.
- Stall: while OutValid && !OutReady, Sum, CarryOut and Overflow are held stable.
- Simultaneous transfer and accept: the new result replaces the old and OutValid stays 1. This gives one result per cycle.
- Idle: transfer with no accept drives OutValid to 0.
- Mode 00, add: {CarryOut,Sum} = Input1 + Input2, computed at WIDTH+1 bits. Overflow = operand MSBs equal and Sum MSB different.
- Mode 01, subtract: {CarryOut,Sum} = Input1 + ~Input2 + 1. CarryOut=1 means no borrow. Overflow = operand MSBs differ and Sum MSB differs from Input1 MSB.
- Mode 10, accumulate: flags and Sum computed as add on (acc, Input1); acc <= Sum. The accumulator is updated only on accept.
- Mode 11, clear: acc <= ACC_INIT, Sum = ACC_INIT, CarryOut=0, Overflow=0. A clear result is still emitted and handshaken.
- Wrap-around: results wrap modulo 2^WIDTH; no saturation unless the optional feature is compiled in.
- AccValue reflects the registered accumulator and changes the cycle after an accepting accumulate or clear.
- No state machine beyond the output-valid bit: states EMPTY (OutValid=0) and FULL (OutValid=1).
  - EMPTY to FULL on accept.
  - FULL to EMPTY on transfer without accept.
  - FULL stays FULL on accept, with or without transfer.

Optional Feature:
- Macro: ADDER_SATURATE_EN.
- Defined: modes 00, 01 and 10 clamp Sum on signed overflow. The result is 0111..1 when the true result is positive and 1000..0 when negative. The accumulator stores the clamped value. Overflow still reports that clamping occurred; CarryOut is unchanged.
- Undefined: pure wrap-around and no clamp logic.

Decomposition:
- Shared package: mode encodings MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC=2'b10, MODE_CLR=2'b11, plus the result/flag struct (sum, carry, ovf).
- One combinational sub-module, add_sub_core, with ports A, B, Sub, Sum, CarryOut and Overflow (plus saturation when ADDER_SATURATE_EN is defined).
- The top level holds the handshake, output register and accumulator.

Test Plan:
- Reset check: Reset=1 for 2 cycles with InValid=1 -> OutValid=0, Sum=0, AccValue=ACC_INIT; no result emitted.
- WIDTH=8 add: 200+100 -> Sum=44, CarryOut=1, Overflow=0. Then 100+100 -> Sum=200, CarryOut=0, Overflow=1, each one cycle after accept.
- Subtract: 5-7 -> Sum=254, CarryOut=0, Overflow=0. Then 128-1 -> Sum=127, Overflow=1.
- Accumulate: 10, 20, 30 then clear -> Sum sequence 10, 30, 60, 0; AccValue ends at 0.
- Backpressure: OutReady=0 for 3 cycles with InValid=1 -> InReady=0, Sum held. On OutReady=1, the next result lands the same cycle; no loss and no duplicate over a 100-op random stream checked against a model.
- With ADDER_SATURATE_EN defined: 100+100 -> Sum=127, Overflow=1. Then (-100)+(-100) -> Sum=128 (0x80), Overflow=1.
